// File: rtl/fma_dot_seq.sv
// Dot-product sequencer around a combinational bf16*bf16+fp32 FMA with a registered accumulator.
// Optional FMA_DOT_RELU_EN clamps negative results to +0 on out_data.

module fma_dot_fma (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [31:0] c,
   output logic [31:0] mul_out,
   output logic [31:0] out
);
   logic               w_ps, w_p_big, w_big_s, w_sml_s, w_inc;
   logic        [15:0] w_prod;
   logic        [23:0] w_psig, w_csig, w_big_sig, w_sml_sig;
   logic signed [9:0]  w_pe, w_ce, w_big_e, w_sml_e, w_diff, w_res_e, w_re;
   logic        [27:0] w_big_x, w_sml_x, w_sum;
   logic        [26:0] w_norm;
   logic        [24:0] w_rsig;
   logic        [4:0]  w_lz;

   always_comb begin
      w_ps   = a[15] ^ b[15];
      w_prod = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
      if (w_prod[15]) begin
         w_psig = {w_prod, 8'h0};
         w_pe   = signed'({2'b0, a[14:7]}) + signed'({2'b0, b[14:7]}) - 10'sd126;
      end else begin
         w_psig = {w_prod[14:0], 9'h0};
         w_pe   = signed'({2'b0, a[14:7]}) + signed'({2'b0, b[14:7]}) - 10'sd127;
      end
      mul_out = {w_ps, w_pe[7:0], w_psig[22:0]};

      w_csig  = {1'b1, c[22:0]};
      w_ce    = signed'({2'b0, c[30:23]});
      w_p_big = (w_pe > w_ce) || ((w_pe == w_ce) && (w_psig >= w_csig));
      w_big_s   = w_p_big ? w_ps   : c[31];
      w_sml_s   = w_p_big ? c[31]  : w_ps;
      w_big_e   = w_p_big ? w_pe   : w_ce;
      w_sml_e   = w_p_big ? w_ce   : w_pe;
      w_big_sig = w_p_big ? w_psig : w_csig;
      w_sml_sig = w_p_big ? w_csig : w_psig;
      w_diff    = w_big_e - w_sml_e;

      // three guard bits below the significand; bits shifted further out are dropped
      w_big_x = {1'b0, w_big_sig, 3'b0};
      w_sml_x = (w_diff > 10'sd27) ? 28'h0 : ({1'b0, w_sml_sig, 3'b0} >> w_diff);
      w_sum   = (w_big_s == w_sml_s) ? (w_big_x + w_sml_x) : (w_big_x - w_sml_x);

      w_lz = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (w_sum[i]) w_lz = 5'(26 - i);
      end
      if (w_sum[27]) begin
         w_norm  = w_sum[27:1];
         w_res_e = w_big_e + 10'sd1;
      end else begin
         w_norm  = w_sum[26:0] << w_lz;
         w_res_e = w_big_e - signed'({5'b0, w_lz});
      end

      w_inc  = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
      w_rsig = {1'b0, w_norm[26:3]} + {24'h0, w_inc};
      w_re   = w_res_e + signed'({9'h0, w_rsig[24]});

      if (!(w_rsig[24] || w_rsig[23]) || (w_re < 10'sd1))
         out = 32'h0;
      else if (w_re > 10'sd254)
         out = {w_big_s, 8'hFF, 23'h0};
      else
         out = {w_big_s, w_re[7:0], w_rsig[24] ? w_rsig[23:1] : w_rsig[22:0]};
   end
endmodule

// state | meaning
// IDLE  | waiting for the first pair of a vector; addend is bias
// ACCUM | accepting the remaining pairs; addend is the accumulator
// DONE  | result held on out_data until out_ready
module fma_dot_seq #(
   parameter int VEC_LEN = 16,
   parameter int CNT_W   = $clog2(VEC_LEN) + 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   input  logic [31:0] bias,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   state_t           r_state;
   logic [31:0]      r_acc, r_out_data;
   logic [CNT_W-1:0] r_cnt;
   logic             r_in_ready, r_out_valid, r_busy;

   logic             w_accept, w_pz, w_cz;
   logic [31:0]      w_c, w_mul, w_fma, w_next, w_out_val;

   assign w_accept = in_valid && r_in_ready;
   assign w_c      = (r_state == S_IDLE) ? bias : r_acc;
   // the FMA assumes a hidden leading one, so zero operands bypass it
   assign w_pz     = (in_a[14:7] == 8'h0) || (in_b[14:7] == 8'h0);
   assign w_cz     = (w_c[30:23] == 8'h0);
   assign w_next   = w_pz ? w_c : (w_cz ? w_mul : w_fma);

`ifdef FMA_DOT_RELU_EN
   assign w_out_val = w_next[31] ? 32'h0 : w_next;
`else
   assign w_out_val = w_next;
`endif

   fma_dot_fma u_fma (
      .a       (in_a),
      .b       (in_b),
      .c       (w_c),
      .mul_out (w_mul),
      .out     (w_fma)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_acc       <= 32'h0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= 32'h0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_acc  <= w_next;
                  r_cnt  <= CNT_W'(1);
                  r_busy <= 1'b1;
                  if (VEC_LEN == 1) begin
                     r_state     <= S_DONE;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_out_val;
                  end else begin
                     r_state <= S_ACCUM;
                  end
               end
            end
            S_ACCUM: begin
               if (w_accept) begin
                  r_acc <= w_next;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_W'(VEC_LEN - 1)) begin
                     r_state     <= S_DONE;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_out_val;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_cnt       <= '0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = r_busy;
endmodule

// File: tb/tb_fma_dot_seq.sv
// Bench for fma_dot_seq: small-integer operands so the expected dot product is exact integer arithmetic.
// Honours FMA_DOT_RELU_EN the same way the design does.

module tb_fma_dot_seq;
   logic        clk = 1'b0;
   logic        rst_n;

   logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_busy;
   logic [15:0] d1_in_a, d1_in_b;
   logic [31:0] d1_bias, d1_out_data;

   logic        d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready, d4_busy;
   logic [15:0] d4_in_a, d4_in_b;
   logic [31:0] d4_bias, d4_out_data;

   int n_vec = 0;
   int n_err = 0;
   int va[4], vb[4], vg[4];

   always #5 clk = ~clk;

   fma_dot_seq #(.VEC_LEN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
      .in_a(d1_in_a), .in_b(d1_in_b), .bias(d1_bias), .out_valid(d1_out_valid),
      .out_ready(d1_out_ready), .out_data(d1_out_data), .busy(d1_busy)
   );

   fma_dot_seq #(.VEC_LEN(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
      .in_a(d4_in_a), .in_b(d4_in_b), .bias(d4_bias), .out_valid(d4_out_valid),
      .out_ready(d4_out_ready), .out_data(d4_out_data), .busy(d4_busy)
   );

   function automatic logic [31:0] int_to_fp32(input int v);
      int m, e;
      logic [31:0] mant;
      if (v == 0) return 32'h0;
      m = (v < 0) ? -v : v;
      e = 0;
      while ((m >> (e + 1)) != 0) e++;
      mant = 32'(m) << (23 - e);
      return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + e), mant[22:0]};
   endfunction

   function automatic logic [15:0] bf16(input int v);
      logic [31:0] t;
      t = int_to_fp32(v);
      return t[31:16];
   endfunction

   function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef FMA_DOT_RELU_EN
      return x[31] ? 32'h0 : x;
`else
      return x;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run1(input int a, input int b, input int bias_i, input string tag);
      logic [31:0] e;
      e = relu(int_to_fp32(bias_i + a * b));
      d1_in_valid = 1'b1;
      d1_in_a     = bf16(a);
      d1_in_b     = bf16(b);
      d1_bias     = int_to_fp32(bias_i);
      chk({tag, ".rdy"}, 32'(d1_in_ready), 32'd1);
      tick();
      d1_in_a = 16'($urandom);
      d1_bias = $urandom;
      chk({tag, ".ov"},   32'(d1_out_valid), 32'd1);
      chk({tag, ".data"}, d1_out_data, e);
      chk({tag, ".nrdy"}, 32'(d1_in_ready), 32'd0);
      chk({tag, ".busy"}, 32'(d1_busy), 32'd1);
      tick();
      chk({tag, ".hold"}, d1_out_data, e);
      chk({tag, ".nrdy2"}, 32'(d1_in_ready), 32'd0);
      d1_out_ready = 1'b1;
      tick();
      d1_out_ready = 1'b0;
      d1_in_valid  = 1'b0;
      chk({tag, ".ov0"},  32'(d1_out_valid), 32'd0);
      chk({tag, ".rdy1"}, 32'(d1_in_ready), 32'd1);
   endtask

   task automatic run4(input int bias_i, input int hold, input string tag);
      int          e_int;
      logic [31:0] e;
      e_int = bias_i;
      for (int k = 0; k < 4; k++) e_int += va[k] * vb[k];
      e = relu(int_to_fp32(e_int));
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < vg[k]; g++) begin
            d4_in_valid = 1'b0;
            d4_in_a     = 16'($urandom);
            d4_bias     = $urandom;
            tick();
            chk({tag, ".gap_ov"}, 32'(d4_out_valid), 32'd0);
         end
         d4_in_valid = 1'b1;
         d4_in_a     = bf16(va[k]);
         d4_in_b     = bf16(vb[k]);
         d4_bias     = (k == 0) ? int_to_fp32(bias_i) : $urandom;
         chk({tag, ".rdy"}, 32'(d4_in_ready), 32'd1);
         tick();
         chk({tag, ".ov"}, 32'(d4_out_valid), (k == 3) ? 32'd1 : 32'd0);
      end
      d4_in_valid = 1'b1;
      d4_in_a     = bf16(3);
      d4_in_b     = bf16(5);
      d4_bias     = $urandom;
      chk({tag, ".data"}, d4_out_data, e);
      chk({tag, ".busy"}, 32'(d4_busy), 32'd1);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk({tag, ".hold_ov"},   32'(d4_out_valid), 32'd1);
         chk({tag, ".hold_data"}, d4_out_data, e);
         chk({tag, ".hold_nrdy"}, 32'(d4_in_ready), 32'd0);
      end
      d4_out_ready = 1'b1;
      tick();
      d4_out_ready = 1'b0;
      d4_in_valid  = 1'b0;
      chk({tag, ".ov0"},   32'(d4_out_valid), 32'd0);
      chk({tag, ".rdy1"},  32'(d4_in_ready), 32'd1);
      chk({tag, ".busy0"}, 32'(d4_busy), 32'd0);
   endtask

   function automatic int rnd_op();
      return ($urandom_range(4) == 0) ? 0 : int'($urandom_range(16)) - 8;
   endfunction

   function automatic int rnd_bias();
      return ($urandom_range(3) == 0) ? 0 : int'($urandom_range(200)) - 100;
   endfunction

   initial begin
      rst_n = 1'b0;
      d1_in_valid = 1'b0; d1_in_a = 16'h0; d1_in_b = 16'h0; d1_bias = 32'h0; d1_out_ready = 1'b0;
      d4_in_valid = 1'b0; d4_in_a = 16'h0; d4_in_b = 16'h0; d4_bias = 32'h0; d4_out_ready = 1'b0;
      repeat (2) tick();
      chk("rst.rdy",  32'(d4_in_ready), 32'd1);
      chk("rst.ov",   32'(d4_out_valid), 32'd0);
      chk("rst.data", d4_out_data, 32'h0);
      chk("rst.busy", 32'(d4_busy), 32'd0);
      chk("rst.rdy1", 32'(d1_in_ready), 32'd1);
      chk("rst.ov1",  32'(d1_out_valid), 32'd0);
      rst_n = 1'b1;
      tick();

      run1(1, 2, 0, "len1");
      chk("len1.exact", d1_out_data, 32'h40000000);

      for (int k = 0; k < 4; k++) begin va[k] = 0; vb[k] = rnd_op(); end
      vg[0] = 0; vg[1] = 0; vg[2] = 2; vg[3] = 1;
      run4(1, 0, "zprod");

      for (int k = 0; k < 4; k++) begin va[k] = rnd_op(); vb[k] = rnd_op(); vg[k] = 0; end
      run4(rnd_bias(), 5, "stall");

      for (int k = 0; k < 2; k++) begin
         d4_in_valid = 1'b1; d4_in_a = bf16(7); d4_in_b = bf16(3); d4_bias = int_to_fp32(9);
         tick();
      end
      d4_in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst.rdy",  32'(d4_in_ready), 32'd1);
      chk("mrst.ov",   32'(d4_out_valid), 32'd0);
      chk("mrst.busy", 32'(d4_busy), 32'd0);
      for (int k = 0; k < 4; k++) begin va[k] = 1; vb[k] = 1; vg[k] = 0; end
      run4(0, 0, "mrst");
      chk("mrst.exact", d4_out_data, 32'h40800000);

      for (int k = 0; k < 4; k++) begin va[k] = 0; vb[k] = (k == 1) ? 0 : 5; vg[k] = 0; end
      run4(-1, 1, "negbias");

      for (int k = 0; k < 4; k++) begin va[k] = k + 2; vb[k] = 3; vg[k] = 0; end
      run4(50, 0, "b2b_a");
      for (int k = 0; k < 4; k++) begin va[k] = 1; vb[k] = -2; end
      run4(-3, 0, "b2b_b");

      for (int n = 0; n < 16; n++) begin
         for (int k = 0; k < 4; k++) begin
            va[k] = rnd_op();
            vb[k] = rnd_op();
            vg[k] = int'($urandom_range(2));
         end
         run4(rnd_bias(), int'($urandom_range(2)), "rnd4");
      end
      for (int n = 0; n < 6; n++) run1(rnd_op(), rnd_op(), rnd_bias(), "rnd1");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
